// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer: per-channel state encoding
// and the ceiling-log2 helper used to size the stable-count counters.
package button_debounce_pkg;

    // Per-channel debounce state; PEND_* means a new value is being timed.
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } state_e;

    // Smallest n with 2**n >= value (returns 0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// Single-bit debounce channel: two-flop synchroniser, stable-count timer
// and a four-state FSM with registered level and one-cycle edge pulses.
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = clog2(STABLE_CYCLES + 1);
    // The cycle that reaches STABLE_CYCLES is itself counted, so acceptance
    // fires when the count so far is one short of the target.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_run_done;

    // Counter is 0 in both STABLE states, so STABLE_CYCLES=1 accepts at once.
    assign w_run_done = (r_cnt == LAST_CNT);

    // Two-flop synchroniser; only r_s2 is used by the filter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM: time a run of differing samples, accept or reject it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                ST_STABLE_LO, ST_PEND_HI: begin
                    if (!r_s2) begin
                        // Bounce back to the accepted level restarts the count.
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                    end else if (w_run_done) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_state <= ST_PEND_HI;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE_HI, ST_PEND_LO: begin
                    if (r_s2) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                    end else if (w_run_done) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_state <= ST_PEND_LO;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: one independent debounce channel
// per input bit, producing clean levels plus rise/fall pulses.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[g]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector table, hand-written bounce and
// reset sequences, then random stimulus against a sliding-window model.
module tb_button_debounce;

    localparam int unsigned W  = 2;
    localparam int unsigned SC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] btn_raw;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         w_y;

    int n_vec = 0;
    int n_err = 0;

    button_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // Downstream AND gate fed by the debounced levels.
    assign w_y = level[0] & level[1];

    always #5 clk = ~clk;

    // Reference model: a level flips once the last SC synchronised samples
    // seen by the filter all disagree with it.
    logic [W-1:0]  m_s1, m_s2, m_lvl, m_rise, m_fall;
    logic [SC-1:0] m_win [W];

    task automatic model_step(input logic rst, input logic [W-1:0] btn);
        logic [W-1:0] seen;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
            for (int c = 0; c < W; c++) m_win[c] = '0;
        end else begin
            seen   = m_s2;
            m_s2   = m_s1;
            m_s1   = btn;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) begin
                m_win[c] = (m_win[c] << 1) | SC'(seen[c]);
                if (m_lvl[c] ? (m_win[c] == '0) : (m_win[c] == '1)) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) m_rise[c] = 1'b1;
                    else          m_fall[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs away from the edge, clock once, then let outputs settle.
    task automatic step(input logic rst, input logic [W-1:0] btn);
        rst_n   = rst;
        btn_raw = btn;
        @(posedge clk);
        model_step(rst, btn);
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] btn;
        logic [W-1:0] lvl;
        logic [W-1:0] rse;
        logic [W-1:0] fal;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [W-1:0] b, input logic [W-1:0] l,
                                input logic [W-1:0] rs, input logic [W-1:0] f);
        vec_t v;
        v.rst = r; v.btn = b; v.lvl = l; v.rse = rs; v.fal = f;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;

        // Reset held with both buttons pressed, then release: accept at edge 5.
        for (int i = 0; i < 3; i++) add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 5; k++) add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
        add(1'b1, 2'b11, 2'b11, 2'b11, 2'b00);
        add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
        // Release channel 0: fall at edge 5, channel 1 untouched.
        for (int k = 0; k < 5; k++) add(1'b1, 2'b10, 2'b11, 2'b00, 2'b00);
        add(1'b1, 2'b10, 2'b10, 2'b00, 2'b01);
        add(1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
        // Clean press on channel 0.
        for (int k = 0; k < 5; k++) add(1'b1, 2'b11, 2'b10, 2'b00, 2'b00);
        add(1'b1, 2'b11, 2'b11, 2'b01, 2'b00);
        add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].btn);
            check($sformatf("vec%0d level", i), level, vecs[i].lvl);
            check($sformatf("vec%0d rise", i), rise, vecs[i].rse);
            check($sformatf("vec%0d fall", i), fall, vecs[i].fal);
        end

        // Bounce on channel 0 while channel 1 is already accepted high.
        begin
            logic [6:0] pat;
            pat = 7'b0111011; // applied LSB first: 1,1,0,1,1,1,0
            step(1'b0, 2'b00);
            step(1'b0, 2'b00);
            for (int k = 0; k < 6; k++) step(1'b1, 2'b10);
            check("ch1 pre-accept", level, 2'b10);
            for (int k = 0; k < 7; k++) begin
                step(1'b1, {1'b1, pat[k]});
                check("bounce level", level, 2'b10);
                check("bounce rise", rise, 2'b00);
                check("bounce y", {1'b0, w_y}, 2'b00);
            end
            for (int k = 0; k <= 5; k++) begin
                step(1'b1, 2'b11);
                check("post-bounce level", level, (k == 5) ? 2'b11 : 2'b10);
                check("post-bounce rise", rise, (k == 5) ? 2'b01 : 2'b00);
                check("post-bounce y", {1'b0, w_y}, (k == 5) ? 2'b01 : 2'b00);
            end
        end

        // Reset in the middle of a pending press on channel 1.
        step(1'b0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b10);
            check("pend level", level, 2'b00);
        end
        step(1'b0, 2'b10);
        check("mid-reset level", level, 2'b00);
        for (int k = 0; k <= 5; k++) begin
            step(1'b1, 2'b10);
            check("restart level", level, (k == 5) ? 2'b10 : 2'b00);
            check("restart rise", rise, (k == 5) ? 2'b10 : 2'b00);
        end

        // Random bouncy stimulus against the model, with occasional resets.
        begin
            logic [W-1:0] b;
            logic         r;
            b = '0;
            for (int n = 0; n < 800; n++) begin
                for (int c = 0; c < W; c++) begin
                    if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
                end
                r = ($urandom_range(0, 99) != 0);
                step(r, b);
                check("rand level", level, m_lvl);
                check("rand rise", rise, m_rise);
                check("rand fall", fall, m_fall);
                check("rand rise&fall", rise & fall, 2'b00);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
